// File: rtl/complex_mult_pkg.sv
// Shared definitions for the complex accumulator datapath.
//
// Purpose : holds the default parameter values used by complex_accumulator
//           and the state encoding of its control FSM.
// Ports   : none (package).
// Config  : none here; the optional saturation feature is selected with
//           COMPLEX_ACCUMULATOR_SAT_EN in complex_acc_lane.sv.

package complex_mult_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_GUARD_BITS = 4;
    localparam int DEFAULT_LEN_WIDTH  = 8;

    // ACC collects terms, OUT presents the finished sum downstream.
    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } acc_state_t;

endpackage

// File: rtl/complex_acc_lane.sv
// One accumulator lane (used once for the real and once for the imaginary part).
//
// Purpose : sign-extends a two's complement addend to ACC_W bits and adds it
//           to a running sum; a clear resets the sum.
// Ports   : clk     - clock, rising edge
//           rstn    - asynchronous active-low reset
//           clear   - synchronous clear of the sum (wins over add_en)
//           add_en  - add the addend this cycle
//           addend  - IN_W-bit two's complement term
//           acc     - current ACC_W-bit sum
// Config  : COMPLEX_ACCUMULATOR_SAT_EN - when defined, each addition clamps to
//           the signed ACC_W range and, once clamped, the sum holds at that
//           bound until the next clear. Otherwise the sum wraps.

module complex_acc_lane
    import complex_mult_pkg::*;
#(
    parameter int IN_W  = 2 * DEFAULT_DATA_WIDTH,
    parameter int ACC_W = 2 * DEFAULT_DATA_WIDTH + DEFAULT_GUARD_BITS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             add_en,
    input  logic [IN_W-1:0]  addend,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] addend_ext;

    assign addend_ext = ACC_W'($signed(addend));
    assign acc        = acc_q;

`ifdef COMPLEX_ACCUMULATOR_SAT_EN
    logic             sat_q;
    logic             sat_d;
    logic [ACC_W:0]   sum_wide;
    logic             overflow;

    // One extra bit detects signed overflow: the top two bits disagree.
    assign sum_wide = {acc_q[ACC_W-1], acc_q} + {addend_ext[ACC_W-1], addend_ext};
    assign overflow = sum_wide[ACC_W] != sum_wide[ACC_W-1];

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clear) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (add_en && !sat_q) begin
            if (overflow) begin
                // Sign of the wide sum tells which bound was crossed.
                acc_d = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
                sat_d = 1'b1;
            end else begin
                acc_d = sum_wide[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end
`else
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = acc_q + addend_ext;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

endmodule

// File: rtl/complex_accumulator.sv
// Complex accumulator: sums cfg_len complex products and hands the sum on.
//
// Purpose : accepts products from a complex multiplier over a valid/ready
//           handshake, accumulates real and imaginary parts separately, and
//           presents the finished sum on a second valid/ready handshake.
// Ports   : clk       - clock, rising edge
//           rstn      - asynchronous active-low reset
//           sw_rst    - synchronous software reset, discards any sum in flight
//           cfg_len   - products per sum, latched on the first term (0 acts as 1)
//           in_val    - product valid
//           in_ready  - block accepts a product (high while accumulating)
//           in_data   - product {real, imag}, each 2*DATA_WIDTH two's complement
//           out_val   - sum valid (high while presenting)
//           out_ready - downstream accepts the sum
//           out_data  - sum {real, imag}, each ACC_W two's complement
// Config  : COMPLEX_ACCUMULATOR_SAT_EN - saturating instead of wrapping lanes.

module complex_accumulator
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int GUARD_BITS = DEFAULT_GUARD_BITS,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    input  logic                    in_val,
    output logic                    in_ready,
    input  logic [4*DATA_WIDTH-1:0] in_data,
    output logic                    out_val,
    input  logic                    out_ready,
    output logic [2*(2*DATA_WIDTH+GUARD_BITS)-1:0] out_data
);

    localparam int ACC_W = 2 * DATA_WIDTH + GUARD_BITS;

    acc_state_t           state_q;
    acc_state_t           state_d;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] cnt_d;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_d;
    logic [LEN_WIDTH-1:0] eff_len;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 lane_clear;
    logic [ACC_W-1:0]     acc_re;
    logic [ACC_W-1:0]     acc_im;

    // Handshake flags come straight from the state register so that an
    // asynchronous reset drops out_val and raises in_ready without a clock.
    assign in_ready   = (state_q == ACC);
    assign out_val    = (state_q == OUT);
    assign in_xfer    = in_val && in_ready;
    assign out_xfer   = out_val && out_ready;
    assign lane_clear = sw_rst || out_xfer;
    assign cnt_inc    = cnt_q + LEN_WIDTH'(1);

    // The first term of a sum uses the live cfg_len; later terms use the
    // copy taken on that first term, so mid-sum changes wait for the next sum.
    assign eff_len = (cnt_q != '0) ? len_q
                   : ((cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len);

    // Next-state logic; sw_rst overrides any transfer in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (sw_rst) begin
            state_d = ACC;
            cnt_d   = '0;
            len_d   = '0;
        end else if (in_xfer) begin
            if (cnt_q == '0) begin
                len_d = eff_len;
            end
            cnt_d = cnt_inc;
            if (cnt_inc == eff_len) begin
                state_d = OUT;
            end
        end else if (out_xfer) begin
            state_d = ACC;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ACC;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    complex_acc_lane #(
        .IN_W  (2 * DATA_WIDTH),
        .ACC_W (ACC_W)
    ) u_lane_re (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (lane_clear),
        .add_en (in_xfer),
        .addend (in_data[4*DATA_WIDTH-1:2*DATA_WIDTH]),
        .acc    (acc_re)
    );

    complex_acc_lane #(
        .IN_W  (2 * DATA_WIDTH),
        .ACC_W (ACC_W)
    ) u_lane_im (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (lane_clear),
        .add_en (in_xfer),
        .addend (in_data[2*DATA_WIDTH-1:0]),
        .acc    (acc_im)
    );

    // Accumulators cannot change while in OUT, so the sum stays stable.
    assign out_data = {acc_re, acc_im};

endmodule

// File: tb/tb_complex_accumulator.sv
// Self-checking testbench for complex_accumulator.
//
// Purpose : drives directed and randomized product streams and compares the
//           handshake flags and sums against a plain-arithmetic reference.
// Config  : honours COMPLEX_ACCUMULATOR_SAT_EN in the reference model.

module tb_complex_accumulator;

    localparam int  DW      = 8;
    localparam int  GB      = 4;
    localparam int  LW      = 8;
    localparam int  ACC_W   = 2 * DW + GB;
    localparam longint SAT_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint SAT_MIN = -(longint'(1) <<< (ACC_W - 1));

    logic                 clk       = 1'b0;
    logic                 rstn      = 1'b0;
    logic                 sw_rst    = 1'b0;
    logic [LW-1:0]        cfg_len   = '0;
    logic                 in_val    = 1'b0;
    logic                 in_ready;
    logic [4*DW-1:0]      in_data   = '0;
    logic                 out_val;
    logic                 out_ready = 1'b0;
    logic [2*ACC_W-1:0]   out_data;

    int checks = 0;
    int errors = 0;

    // Reference model: running sums as wide integers, term count, length.
    longint m_re;
    longint m_im;
    bit     m_sat_re;
    bit     m_sat_im;
    int     m_cnt;
    int     m_len;
    logic [2*ACC_W-1:0] exp_q[$];

    complex_accumulator #(
        .DATA_WIDTH (DW),
        .GUARD_BITS (GB),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_rst    (sw_rst),
        .cfg_len   (cfg_len),
        .in_val    (in_val),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_val   (out_val),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [2*ACC_W-1:0] pack_sum(input longint re, input longint im);
        logic [63:0] a;
        logic [63:0] b;
        a = re;
        b = im;
        return {a[ACC_W-1:0], b[ACC_W-1:0]};
    endfunction

    task automatic model_comp(input longint acc, input longint term, input bit sat_in,
                              output longint acc_out, output bit sat_out);
        longint s;
        s       = acc;
        sat_out = sat_in;
`ifdef COMPLEX_ACCUMULATOR_SAT_EN
        if (!sat_in) begin
            s = acc + term;
            if (s > SAT_MAX) begin
                s       = SAT_MAX;
                sat_out = 1'b1;
            end else if (s < SAT_MIN) begin
                s       = SAT_MIN;
                sat_out = 1'b1;
            end
        end
`else
        s = acc + term;
`endif
        acc_out = s;
    endtask

    task automatic model_clear_sum();
        m_re     = 0;
        m_im     = 0;
        m_sat_re = 1'b0;
        m_sat_im = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one product, waits for it to be accepted, updates the model and
    // checks that out_val rises exactly one cycle after the closing term.
    task automatic applyStimulus(input int re, input int im);
        logic [31:0] r;
        logic [31:0] i;
        bit          xfer;
        bit          done;
        int          guard;
        r       = re;
        i       = im;
        in_data = {r[2*DW-1:0], i[2*DW-1:0]};
        in_val  = 1'b1;
        xfer    = 1'b0;
        guard   = 0;
        while (!xfer && guard < 50) begin
            xfer = in_ready;
            tick();
            guard++;
        end
        in_val = 1'b0;
        checks++;
        assert (xfer === 1'b1) else begin
            errors++;
            $error("[TB] FAIL accept observed %0b expected 1", xfer);
        end
        done = 1'b0;
        if (xfer) begin
            if (m_cnt == 0) m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
            model_comp(m_re, longint'(re), m_sat_re, m_re, m_sat_re);
            model_comp(m_im, longint'(im), m_sat_im, m_im, m_sat_im);
            m_cnt++;
            if (m_cnt == m_len) begin
                exp_q.push_back(pack_sum(m_re, m_im));
                model_clear_sum();
                done = 1'b1;
            end
        end
        checks++;
        assert (out_val === done) else begin
            errors++;
            $error("[TB] FAIL out_val_latency observed %0b expected %0b", out_val, done);
        end
    endtask

    // Waits for a sum, holds it under backpressure for 'hold' cycles while
    // pulsing in_val, then accepts it and checks the return to accumulating.
    task automatic checkOutput(input int hold);
        logic [2*ACC_W-1:0] exp_sum;
        int guard;
        guard = 0;
        while (out_val !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        assert (out_val === 1'b1) else begin
            errors++;
            $error("[TB] FAIL out_val_wait observed %0b expected 1", out_val);
        end
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("[TB] FAIL exp_queue observed %0d expected >0", exp_q.size());
        end
        exp_sum = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int c = 0; c < hold; c++) begin
            in_val  = ($urandom_range(0, 1) == 1);
            in_data = $urandom();
            tick();
            checks++;
            assert (in_ready === 1'b0 && out_data === exp_sum) else begin
                errors++;
                $error("[TB] FAIL hold in_ready=%0b data=%h expected 0/%h",
                       in_ready, out_data, exp_sum);
            end
        end
        in_val    = 1'b0;
        out_ready = 1'b1;
        checks++;
        assert (out_data === exp_sum) else begin
            errors++;
            $error("[TB] FAIL sum observed %h expected %h", out_data, exp_sum);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        assert (out_val === 1'b0 && in_ready === 1'b1) else begin
            errors++;
            $error("[TB] FAIL after_out out_val=%0b in_ready=%0b expected 0/1",
                   out_val, in_ready);
        end
    endtask

    initial begin
        bit  fin;
        int  n;
        int  re;
        int  im;

        model_clear_sum();
        m_len = 0;

        // Power-on reset.
        #2;
        checks++;
        assert (in_ready === 1'b1 && out_val === 1'b0 && out_data === '0) else begin
            errors++;
            $error("[TB] FAIL reset in_ready=%0b out_val=%0b data=%h", in_ready, out_val, out_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();

        $display("[TB] basic sum with backpressure");
        cfg_len = 3;
        applyStimulus(10, 1);
        applyStimulus(20, 2);
        applyStimulus(-5, 3);
        checkOutput(5);

        $display("[TB] length 0 and 1");
        cfg_len = 0;
        applyStimulus(7, -7);
        checkOutput(0);
        cfg_len = 1;
        applyStimulus(3, 4);
        checkOutput(1);

        $display("[TB] cfg_len change mid-sum");
        cfg_len = 3;
        applyStimulus(1, 2);
        cfg_len = 2;
        applyStimulus(3, 4);
        applyStimulus(5, 6);
        checkOutput(0);

        $display("[TB] software reset mid-sum");
        cfg_len = 4;
        applyStimulus(100, 100);
        applyStimulus(100, 100);
        sw_rst  = 1'b1;
        in_val  = 1'b1;
        in_data = {16'd50, 16'd50};
        tick();
        sw_rst = 1'b0;
        in_val = 1'b0;
        model_clear_sum();
        checks++;
        assert (out_val === 1'b0 && in_ready === 1'b1 && out_data === '0) else begin
            errors++;
            $error("[TB] FAIL sw_rst out_val=%0b in_ready=%0b data=%h expected 0/1/0",
                   out_val, in_ready, out_data);
        end
        for (int k = 0; k < 4; k++) applyStimulus(1, 1);
        checkOutput(0);

        $display("[TB] overflow");
        cfg_len = 17;
        for (int k = 0; k < 17; k++) applyStimulus(32767, -32768);
        checkOutput(2);

        $display("[TB] randomized sums");
        for (int s = 0; s < 10; s++) begin
            cfg_len = LW'($urandom_range(0, 6));
            fin = 1'b0;
            n   = 0;
            while (!fin && n < 20) begin
                re = int'($urandom_range(0, 65535)) - 32768;
                im = int'($urandom_range(0, 65535)) - 32768;
                applyStimulus(re, im);
                fin = (exp_q.size() > 0);
                n++;
                if ($urandom_range(0, 3) == 0) cfg_len = LW'($urandom_range(0, 6));
                if ($urandom_range(0, 2) == 0) tick();
            end
            checkOutput(int'($urandom_range(0, 3)));
        end

        $display("[TB] asynchronous reset in OUT");
        cfg_len = 1;
        applyStimulus(9, 9);
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        assert (out_val === 1'b0 && in_ready === 1'b1 && out_data === '0) else begin
            errors++;
            $error("[TB] FAIL async_rst out_val=%0b in_ready=%0b data=%h expected 0/1/0",
                   out_val, in_ready, out_data);
        end
        exp_q.delete();
        model_clear_sum();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        cfg_len = 2;
        applyStimulus(-1, 2);
        applyStimulus(-3, 4);
        checkOutput(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
